// File: rtl/control_state_sequencer_if.sv
// -----------------------------------------------------------------------------
// control_state_sequencer_if
//
// Groups the control sequencer's handshake and status signals into one bundle.
// Clock and reset are not part of the bundle; they stay plain module ports.
//
// Signals
//   run          global enable; 0 freezes the sequencer
//   mem_ready    memory access complete this cycle
//   opcode[5:0]  IR opcode field, valid from REGISTER_FETCH onward
//   state[3:0]   current control state (registered)
//   instr_done   one-cycle retirement pulse
//   halted       high while in HALT
//   illegal_op   sticky undefined-opcode flag
//   instr_count  retired-instruction counter, COUNT_WIDTH bits
//
// Modports
//   master  the controlling side (drives run/mem_ready/opcode)
//   slave   the sequencer itself
// -----------------------------------------------------------------------------
interface control_state_sequencer_if #(
  parameter int COUNT_WIDTH = 16
);

  logic                   run;
  logic                   mem_ready;
  logic [5:0]             opcode;
  logic [3:0]             state;
  logic                   instr_done;
  logic                   halted;
  logic                   illegal_op;
  logic [COUNT_WIDTH-1:0] instr_count;

  modport master (
    output run,
    output mem_ready,
    output opcode,
    input  state,
    input  instr_done,
    input  halted,
    input  illegal_op,
    input  instr_count
  );

  modport slave (
    input  run,
    input  mem_ready,
    input  opcode,
    output state,
    output instr_done,
    output halted,
    output illegal_op,
    output instr_count
  );

endinterface : control_state_sequencer_if

// File: rtl/control_state_sequencer.sv
// -----------------------------------------------------------------------------
// control_state_sequencer
//
// Multicycle control FSM. Each cycle it presents a 4-bit control state that a
// downstream decoder turns into datapath strobes. Instructions walk through
// fetch, register fetch and a class-specific execute path selected from the IR
// opcode; fetch, load and store wait on mem_ready. The block also reports
// retirement (pulse + counter), halt and a sticky illegal-opcode flag.
//
// Ports
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    control_state_sequencer_if.slave
//            inputs : run, mem_ready, opcode
//            outputs: state, instr_done, halted, illegal_op, instr_count
//
// All outputs come straight from flops; there is no input-to-output
// combinational path.
// -----------------------------------------------------------------------------
module control_state_sequencer #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  control_state_sequencer_if.slave   bus
);

  // ---------------------------------------------------------------------------
  // Types
  // ---------------------------------------------------------------------------
  typedef enum logic [3:0] {
    INSTRUCTION_FETCH    = 4'd0,
    REGISTER_FETCH       = 4'd1,
    IMMEDIATE_INJECTION2 = 4'd2,
    ALU_R3               = 4'd3,
    ALU_RI3              = 4'd4,
    ALU4                 = 4'd5,
    BRANCH3              = 4'd6,
    MEM_REF3             = 4'd7,
    LOAD4                = 4'd8,
    STORE4               = 4'd9,
    LOAD5                = 4'd10,
    JUMP3                = 4'd11,
    HALT                 = 4'd12
  } state_t;

  typedef enum logic [3:0] {
    CLS_ALU_R,
    CLS_ALU_RI,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_LOAD_IMM,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_t;

  // Opcode classification used when leaving REGISTER_FETCH.
  function automatic op_class_t decode_opcode(input logic [5:0] op);
    op_class_t cls;
    casez (op)
      6'b00????: cls = CLS_ALU_R;
      6'b01????: cls = CLS_ALU_RI;
      6'b100000: cls = CLS_LOAD;
      6'b100001: cls = CLS_STORE;
      6'b100010: cls = CLS_BRANCH;
      6'b100011: cls = CLS_JUMP;
      6'b110000: cls = CLS_LOAD_IMM;
      6'b111111: cls = CLS_HALT;
      default:   cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  // ---------------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------------
  state_t                 state_q;
  state_t                 state_d;
  op_class_t              op_class;

  logic                   retire;       // an instruction retires on this edge
  logic                   illegal_set;  // an undefined opcode/state is seen

  logic                   instr_done_q;
  logic                   halted_q;
  logic                   illegal_q;
  logic [COUNT_WIDTH-1:0] count_q;

  assign op_class = decode_opcode(bus.opcode);

  // ---------------------------------------------------------------------------
  // Process 1: state register
  // ---------------------------------------------------------------------------
  // NOTE: every flop is written with <= so all registers update from the same
  // pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INSTRUCTION_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Process 2: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d gets a default before the case so every path assigns it;
  // otherwise synthesis would infer a latch on the unassigned branches.
  always_comb begin
    state_d = state_q;
    if (bus.run) begin
      case (state_q)
        INSTRUCTION_FETCH: begin
          if (bus.mem_ready) state_d = REGISTER_FETCH;
        end
        REGISTER_FETCH: begin
          case (op_class)
            CLS_ALU_R:    state_d = ALU_R3;
            CLS_ALU_RI:   state_d = ALU_RI3;
            CLS_LOAD,
            CLS_STORE:    state_d = MEM_REF3;
            CLS_BRANCH:   state_d = BRANCH3;
            CLS_JUMP:     state_d = JUMP3;
            CLS_LOAD_IMM: state_d = IMMEDIATE_INJECTION2;
            CLS_HALT:     state_d = HALT;
            default:      state_d = INSTRUCTION_FETCH;
          endcase
        end
        ALU_R3,
        ALU_RI3:  state_d = ALU4;
        // Opcode is re-sampled here; bit 0 separates STORE from LOAD.
        MEM_REF3: state_d = bus.opcode[0] ? STORE4 : LOAD4;
        LOAD4: begin
          if (bus.mem_ready) state_d = LOAD5;
        end
        STORE4: begin
          if (bus.mem_ready) state_d = INSTRUCTION_FETCH;
        end
        ALU4,
        BRANCH3,
        JUMP3,
        IMMEDIATE_INJECTION2,
        LOAD5:    state_d = INSTRUCTION_FETCH;
        HALT:     state_d = HALT;
        // Encodings 13-15 can only be reached by an upset; recover to fetch.
        default:  state_d = INSTRUCTION_FETCH;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Process 3: output logic (next values for the registered status outputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    retire      = 1'b0;
    illegal_set = 1'b0;
    if (bus.run) begin
      case (state_q)
        REGISTER_FETCH: begin
          retire      = (op_class == CLS_HALT);
          illegal_set = (op_class == CLS_ILLEGAL);
        end
        // Terminal states retire when they hand back to fetch; STORE4 only
        // does so once memory has accepted the write.
        ALU4,
        BRANCH3,
        JUMP3,
        IMMEDIATE_INJECTION2,
        LOAD5:  retire = 1'b1;
        STORE4: retire = bus.mem_ready;
        INSTRUCTION_FETCH,
        ALU_R3,
        ALU_RI3,
        MEM_REF3,
        LOAD4,
        HALT:   retire = 1'b0;
        default: begin
          illegal_set = 1'b1;
        end
      endcase
    end
  end

  // Status registers, updated on the same edge as the state so that
  // instr_done/instr_count/halted line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_done_q <= 1'b0;
      halted_q     <= 1'b0;
      illegal_q    <= 1'b0;
      count_q      <= '0;
    end else begin
      instr_done_q <= retire;
      halted_q     <= (state_d == HALT);
      illegal_q    <= illegal_q | illegal_set;
      if (retire) begin
        count_q <= count_q + COUNT_WIDTH'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.state       = state_q;
  assign bus.instr_done  = instr_done_q;
  assign bus.halted      = halted_q;
  assign bus.illegal_op  = illegal_q;
  assign bus.instr_count = count_q;

endmodule : control_state_sequencer

// File: tb/tb_control_state_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_state_sequencer
//
// Self-checking bench for control_state_sequencer. A 16-bit instance carries
// the directed table, the hand-written corner sequences and a randomized run
// against a path-based reference model; a 2-bit instance shows counter wrap.
// -----------------------------------------------------------------------------
module tb_control_state_sequencer;

  logic clk;
  logic rst_n;

  control_state_sequencer_if #(.COUNT_WIDTH(16)) bus ();
  control_state_sequencer_if #(.COUNT_WIDTH(2))  sbus ();

  control_state_sequencer #(.COUNT_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  control_state_sequencer #(.COUNT_WIDTH(2)) dut_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed table: one instruction per record, mem_ready=1, run=1.
  // seq holds the expected state per cycle as nibbles, nibble 0 first.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [5:0]  op;
    int          len;
    logic [31:0] seq;
    bit          retire;
    bit          illegal;
  } vec_t;

  vec_t vecs[10];

  // ---------------------------------------------------------------------------
  // Reference model: an instruction is a list of states chosen at register
  // fetch; LOAD4/STORE4 wait for memory, the end of the list retires.
  // ---------------------------------------------------------------------------
  int       m_state;
  int       m_tail[$];
  bit       m_done;
  bit       m_ill;
  int       m_cnt;

  task automatic model_step(input bit run, input bit mr, input logic [5:0] op);
    m_done = 1'b0;
    if (!run) return;
    if (m_state == 0) begin
      if (mr) m_state = 1;
    end else if (m_state == 1) begin
      m_tail = {};
      if (op[5:4] == 2'b00)      m_tail = {3, 5};
      else if (op[5:4] == 2'b01) m_tail = {4, 5};
      else if (op == 6'b100000)  m_tail = {7, 8, 10};
      else if (op == 6'b100001)  m_tail = {7, 9};
      else if (op == 6'b100010)  m_tail = {6};
      else if (op == 6'b100011)  m_tail = {11};
      else if (op == 6'b110000)  m_tail = {2};
      if (op == 6'b111111) begin
        m_state = 12;
        m_done  = 1'b1;
      end else if (m_tail.size() == 0) begin
        m_state = 0;
        m_ill   = 1'b1;
      end else begin
        m_state = m_tail.pop_front();
      end
    end else if (m_state == 12) begin
      m_state = 12;
    end else if ((m_state == 8 || m_state == 9) && !mr) begin
      m_state = m_state;
    end else if (m_tail.size() > 0) begin
      m_state = m_tail.pop_front();
    end else begin
      m_state = 0;
      m_done  = 1'b1;
    end
    if (m_done) m_cnt = (m_cnt + 1) % 65536;
  endtask

  logic [5:0] pool[8];

  initial begin
    int exp_cnt;
    bit exp_ill;
    int cnt_before;

    rst_n         = 1'b0;
    bus.run       = 1'b0;
    bus.mem_ready = 1'b0;
    bus.opcode    = 6'd0;
    sbus.run       = 1'b0;
    sbus.mem_ready = 1'b1;
    sbus.opcode    = 6'b000010;

    vecs[0] = '{op: 6'b000010, len: 4, seq: 32'h0000_5310, retire: 1'b1, illegal: 1'b0};
    vecs[1] = '{op: 6'b010011, len: 4, seq: 32'h0000_5410, retire: 1'b1, illegal: 1'b0};
    vecs[2] = '{op: 6'b100000, len: 5, seq: 32'h000A_8710, retire: 1'b1, illegal: 1'b0};
    vecs[3] = '{op: 6'b100001, len: 4, seq: 32'h0000_9710, retire: 1'b1, illegal: 1'b0};
    vecs[4] = '{op: 6'b100010, len: 3, seq: 32'h0000_0610, retire: 1'b1, illegal: 1'b0};
    vecs[5] = '{op: 6'b100011, len: 3, seq: 32'h0000_0B10, retire: 1'b1, illegal: 1'b0};
    vecs[6] = '{op: 6'b110000, len: 3, seq: 32'h0000_0210, retire: 1'b1, illegal: 1'b0};
    vecs[7] = '{op: 6'b101010, len: 2, seq: 32'h0000_0010, retire: 1'b0, illegal: 1'b1};
    vecs[8] = '{op: 6'b111110, len: 2, seq: 32'h0000_0010, retire: 1'b0, illegal: 1'b1};
    vecs[9] = '{op: 6'b001111, len: 4, seq: 32'h0000_5310, retire: 1'b1, illegal: 1'b0};

    pool = '{6'b000101, 6'b011010, 6'b100000, 6'b100001,
             6'b100010, 6'b100011, 6'b110000, 6'b101100};

    // ---------------- reset state ----------------
    #1;
    check("reset_state",  32'(bus.state), 32'd0);
    check("reset_done",   32'(bus.instr_done), 32'd0);
    check("reset_halted", 32'(bus.halted), 32'd0);
    check("reset_ill",    32'(bus.illegal_op), 32'd0);
    check("reset_count",  32'(bus.instr_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- table-driven instructions ----------------
    exp_cnt = 0;
    exp_ill = 1'b0;
    bus.run       = 1'b1;
    bus.mem_ready = 1'b1;
    for (int v = 0; v < 10; v++) begin
      bus.opcode = vecs[v].op;
      for (int k = 0; k < vecs[v].len; k++) begin
        check($sformatf("tbl%0d_state%0d", v, k), 32'(bus.state), 32'(vecs[v].seq[4*k +: 4]));
        if (k > 0) check($sformatf("tbl%0d_nodone%0d", v, k), 32'(bus.instr_done), 32'd0);
        tick();
      end
      if (vecs[v].retire) exp_cnt++;
      if (vecs[v].illegal) exp_ill = 1'b1;
      check($sformatf("tbl%0d_end_state", v), 32'(bus.state), 32'd0);
      check($sformatf("tbl%0d_done", v), 32'(bus.instr_done), 32'(vecs[v].retire));
      check($sformatf("tbl%0d_count", v), 32'(bus.instr_count), 32'(exp_cnt));
      check($sformatf("tbl%0d_ill", v), 32'(bus.illegal_op), 32'(exp_ill));
    end

    // ---------------- run=0 with mem_ready=1 in fetch is not consumed ----------
    bus.opcode = 6'b100000;
    bus.run    = 1'b0;
    tick();
    check("frz_fetch_state", 32'(bus.state), 32'd0);
    check("frz_fetch_done", 32'(bus.instr_done), 32'd0);
    bus.run = 1'b1;

    // ---------------- LOAD with two stall cycles in LOAD4 ----------------
    tick(); check("ld_s1", 32'(bus.state), 32'd1);
    tick(); check("ld_s7", 32'(bus.state), 32'd7);
    tick(); check("ld_s8a", 32'(bus.state), 32'd8);
    bus.mem_ready = 1'b0;
    tick(); check("ld_s8b", 32'(bus.state), 32'd8);
    tick(); check("ld_s8c", 32'(bus.state), 32'd8);
    bus.mem_ready = 1'b1;
    tick(); check("ld_s10", 32'(bus.state), 32'd10);
    tick(); check("ld_s0", 32'(bus.state), 32'd0);
    exp_cnt++;
    check("ld_done", 32'(bus.instr_done), 32'd1);
    check("ld_count", 32'(bus.instr_count), 32'(exp_cnt));

    // ---------------- freeze in ALU_R3 ----------------
    bus.opcode = 6'b000010;
    tick(); tick();
    check("frz_alu_s3", 32'(bus.state), 32'd3);
    bus.run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("frz_alu_hold", 32'(bus.state), 32'd3);
      check("frz_alu_cnt", 32'(bus.instr_count), 32'(exp_cnt));
      check("frz_alu_done", 32'(bus.instr_done), 32'd0);
    end
    bus.run = 1'b1;
    tick(); check("frz_alu_s5", 32'(bus.state), 32'd5);
    tick(); check("frz_alu_s0", 32'(bus.state), 32'd0);
    exp_cnt++;
    check("frz_alu_done_end", 32'(bus.instr_done), 32'd1);
    check("frz_alu_count", 32'(bus.instr_count), 32'(exp_cnt));

    // ---------------- reset mid-LOAD5 ----------------
    bus.opcode = 6'b100000;
    for (int i = 0; i < 4; i++) tick();
    check("rst_ld5_s10", 32'(bus.state), 32'd10);
    rst_n = 1'b0;
    #1;
    check("rst_async_state", 32'(bus.state), 32'd0);
    check("rst_async_count", 32'(bus.instr_count), 32'd0);
    check("rst_async_ill", 32'(bus.illegal_op), 32'd0);
    check("rst_async_done", 32'(bus.instr_done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_first_edge", 32'(bus.state), 32'd1);
    tick(); tick(); tick(); tick();
    check("rst_ld_end", 32'(bus.state), 32'd0);
    check("rst_ld_count", 32'(bus.instr_count), 32'd1);

    // ---------------- illegal is sticky, no retirement ----------------
    do_reset();
    bus.opcode = 6'b101010;
    tick(); check("ill_s1", 32'(bus.state), 32'd1);
    tick(); check("ill_s0", 32'(bus.state), 32'd0);
    check("ill_flag", 32'(bus.illegal_op), 32'd1);
    check("ill_nodone", 32'(bus.instr_done), 32'd0);
    check("ill_nocount", 32'(bus.instr_count), 32'd0);
    bus.opcode = 6'b000010;
    for (int i = 0; i < 4; i++) tick();
    check("ill_sticky", 32'(bus.illegal_op), 32'd1);
    check("ill_r_done", 32'(bus.instr_done), 32'd1);
    check("ill_r_count", 32'(bus.instr_count), 32'd1);

    // ---------------- counter wrap on the 2-bit instance ----------------
    do_reset();
    bus.run  = 1'b0;
    sbus.run = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    sbus.run = 1'b0;
    check("wrap_state", 32'(sbus.state), 32'd0);
    check("wrap_done", 32'(sbus.instr_done), 32'd1);
    check("wrap_count", 32'(sbus.instr_count), 32'd1);

    // ---------------- HALT ----------------
    do_reset();
    bus.run       = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode    = 6'b111111;
    tick(); check("halt_s1", 32'(bus.state), 32'd1);
    check("halt_not_yet", 32'(bus.halted), 32'd0);
    tick();
    check("halt_state", 32'(bus.state), 32'd12);
    check("halt_flag", 32'(bus.halted), 32'd1);
    check("halt_done", 32'(bus.instr_done), 32'd1);
    check("halt_count", 32'(bus.instr_count), 32'd1);
    for (int i = 0; i < 20; i++) begin
      bus.opcode    = 6'($urandom_range(0, 63));
      bus.mem_ready = 1'($urandom_range(0, 1));
      tick();
      check("halt_hold", 32'(bus.state), 32'd12);
      check("halt_hold_done", 32'(bus.instr_done), 32'd0);
      check("halt_hold_flag", 32'(bus.halted), 32'd1);
    end
    do_reset();
    check("halt_rst_state", 32'(bus.state), 32'd0);
    check("halt_rst_flag", 32'(bus.halted), 32'd0);
    check("halt_rst_count", 32'(bus.instr_count), 32'd0);
    check("halt_rst_done", 32'(bus.instr_done), 32'd0);

    // ---------------- randomized run against the model ----------------
    do_reset();
    m_state = 0;
    m_tail  = {};
    m_done  = 1'b0;
    m_ill   = 1'b0;
    m_cnt   = 0;
    for (int c = 0; c < 3000; c++) begin
      logic r;
      logic mr;
      if (m_state == 0) begin
        if ($urandom_range(0, 3) == 0) bus.opcode = 6'($urandom_range(0, 62));
        else                           bus.opcode = pool[$urandom_range(0, 7)];
      end
      r  = ($urandom_range(0, 9) != 0);
      mr = ($urandom_range(0, 9) < 7);
      bus.run       = r;
      bus.mem_ready = mr;
      model_step(r, mr, bus.opcode);
      tick();
      check("rnd_state", 32'(bus.state), 32'(m_state));
      check("rnd_done", 32'(bus.instr_done), 32'(m_done));
      check("rnd_halted", 32'(bus.halted), 32'(m_state == 12));
      check("rnd_ill", 32'(bus.illegal_op), 32'(m_ill));
      check("rnd_count", 32'(bus.instr_count), 32'(m_cnt));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_control_state_sequencer
